// File: rtl/dsm_noise_shaper_if.sv
// Sample bus for the ternary delta-sigma noise shaper.
// The master side presents samples and control; the slave side (the shaper)
// returns the quantised symbols, the output strobe and the overflow flags.
interface dsm_noise_shaper_if #(
  parameter int IN_WIDTH = 13,
  parameter int NUM_CH   = 4
);
  logic                         clear;
  logic                         order_sel;
  logic                         in_valid;
  logic [NUM_CH*IN_WIDTH-1:0]   in_data;
  logic                         out_valid;
  logic [2*NUM_CH-1:0]          sign_out;
  logic [NUM_CH-1:0]            ovf;

  modport master (
    output clear, order_sel, in_valid, in_data,
    input  out_valid, sign_out, ovf
  );

  modport slave (
    input  clear, order_sel, in_valid, in_data,
    output out_valid, sign_out, ovf
  );
endinterface

// File: rtl/dsm_noise_shaper.sv
// Multi-channel ternary delta-sigma noise shaper.
// Each channel quantises its sample to {-1, 0, +1} and feeds the quantisation
// error back through a first-order (1-z^-1) or second-order (1-z^-1)^2 loop.
// Error state saturates symmetrically; any clamp sets a sticky ovf bit.
module dsm_noise_shaper #(
  parameter int IN_WIDTH  = 13,
  parameter int FRAC_BITS = 9,
  parameter int NUM_CH    = 4,
  parameter int ACC_WIDTH = IN_WIDTH + 3,
  parameter int THRESH    = 0
) (
  input  logic               clk,
  input  logic               rst,
  dsm_noise_shaper_if.slave  bus
);

  // v carries two guard bits so x + 2*e1 - e2 can never wrap; the error path
  // needs one more bit because the quantiser step is subtracted from v.
  localparam int VW = ACC_WIDTH + 2;
  localparam int EW = ACC_WIDTH + 3;

  localparam logic signed [VW-1:0] TH_P  = VW'(THRESH);
  localparam logic signed [VW-1:0] TH_N  = -TH_P;
  localparam logic signed [EW-1:0] Q_LSB = EW'(2 ** FRAC_BITS);
  localparam logic signed [EW-1:0] E_MAX = EW'((2 ** (ACC_WIDTH - 1)) - 1);
  localparam logic signed [EW-1:0] E_MIN = -E_MAX;

  localparam logic [1:0] Y_POS  = 2'b01;
  localparam logic [1:0] Y_ZERO = 2'b00;
  localparam logic [1:0] Y_NEG  = 2'b11;

  logic out_valid_q, out_valid_d;

  // Output strobe is a registered copy of an accepted in_valid.
  always_comb begin
    out_valid_d = bus.in_valid & ~bus.clear;
  end

  // Output strobe register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) out_valid_q <= 1'b0;
    else      out_valid_q <= out_valid_d;
  end

  assign bus.out_valid = out_valid_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic signed [ACC_WIDTH-1:0] e1_q, e1_d;
    logic signed [ACC_WIDTH-1:0] e2_q, e2_d;
    logic [1:0]                  sign_q, sign_d;
    logic                        ovf_q, ovf_d;

    logic signed [IN_WIDTH-1:0]  x_raw;
    logic signed [VW-1:0]        x_ext, e1_ext, e2_ext, v;
    logic signed [EW-1:0]        v_ext, q_step, e_full;
    logic [1:0]                  y;
    logic                        sat_hi, sat_lo;
    logic signed [ACC_WIDTH-1:0] e_sat;

    assign x_raw  = bus.in_data[k*IN_WIDTH +: IN_WIDTH];
    assign x_ext  = {{(VW-IN_WIDTH){x_raw[IN_WIDTH-1]}}, x_raw};
    assign e1_ext = {{2{e1_q[ACC_WIDTH-1]}}, e1_q};
    assign e2_ext = {{2{e2_q[ACC_WIDTH-1]}}, e2_q};

    // Loop filter sum; second order adds 2*e1 - e2.
    always_comb begin
      if (bus.order_sel) v = x_ext + (e1_ext <<< 1) - e2_ext;
      else               v = x_ext + e1_ext;
    end

    // Ternary quantiser with symmetric dead zone; v inside [-THRESH, THRESH] gives 0.
    always_comb begin
      if (v > TH_P)      y = Y_POS;
      else if (v < TH_N) y = Y_NEG;
      else               y = Y_ZERO;
    end

    // Quantisation error at full width, then symmetric clamp to the state width.
    always_comb begin
      v_ext = {v[VW-1], v};
      case (y)
        Y_POS:   q_step = Q_LSB;
        Y_NEG:   q_step = -Q_LSB;
        default: q_step = '0;
      endcase
      e_full = v_ext - q_step;
      sat_hi = e_full > E_MAX;
      sat_lo = e_full < E_MIN;
      if (sat_hi)      e_sat = E_MAX[ACC_WIDTH-1:0];
      else if (sat_lo) e_sat = E_MIN[ACC_WIDTH-1:0];
      else             e_sat = e_full[ACC_WIDTH-1:0];
    end

    // Next state: clear beats an accepted sample; otherwise hold.
    // e2 shifts in both modes so order_sel may change between samples.
    always_comb begin
      e1_d   = e1_q;
      e2_d   = e2_q;
      sign_d = sign_q;
      ovf_d  = ovf_q;
      if (bus.clear) begin
        e1_d   = '0;
        e2_d   = '0;
        sign_d = Y_ZERO;
        ovf_d  = 1'b0;
      end else if (bus.in_valid) begin
        e2_d   = e1_q;
        e1_d   = e_sat;
        sign_d = y;
        ovf_d  = ovf_q | sat_hi | sat_lo;
      end
    end

    // Per-channel state registers.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        e1_q   <= '0;
        e2_q   <= '0;
        sign_q <= Y_ZERO;
        ovf_q  <= 1'b0;
      end else begin
        e1_q   <= e1_d;
        e2_q   <= e2_d;
        sign_q <= sign_d;
        ovf_q  <= ovf_d;
      end
    end

    assign bus.sign_out[2*k +: 2] = sign_q;
    assign bus.ovf[k]             = ovf_q;
  end

endmodule

// File: tb/tb_dsm_noise_shaper.sv
// Bench for dsm_noise_shaper: two instances (dead zone 0 and 300) share the
// same stimulus and are compared every cycle against an integer model.
module tb_dsm_noise_shaper;
  localparam int IW = 13;
  localparam int NC = 4;
  localparam int DW = IW * NC;
  localparam int EMAX = 32767;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  dsm_noise_shaper_if #(.IN_WIDTH(IW), .NUM_CH(NC)) ifa ();
  dsm_noise_shaper_if #(.IN_WIDTH(IW), .NUM_CH(NC)) ifb ();

  dsm_noise_shaper #(.IN_WIDTH(IW), .FRAC_BITS(9), .NUM_CH(NC), .THRESH(0))
    u_a (.clk(clk), .rst(rst), .bus(ifa));
  dsm_noise_shaper #(.IN_WIDTH(IW), .FRAC_BITS(9), .NUM_CH(NC), .THRESH(300))
    u_b (.clk(clk), .rst(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference state: [dut][channel]
  int m_e1 [2][NC];
  int m_e2 [2][NC];
  int m_y  [2][NC];
  int m_ov [2][NC];
  int m_ovld;

  function automatic int dec(input logic [1:0] s);
    case (s)
      2'b01:   return 1;
      2'b11:   return -1;
      2'b00:   return 0;
      default: return 99;
    endcase
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < NC; k++) begin
        m_e1[d][k] = 0; m_e2[d][k] = 0; m_y[d][k] = 0; m_ov[d][k] = 0;
      end
    m_ovld = 0;
  endtask

  task automatic model_edge(input bit clr, input bit ord, input bit vld,
                            input logic [DW-1:0] data);
    logic signed [IW-1:0] xs;
    int x, v, th, y, e;
    if (clr) begin
      model_reset();
    end else if (vld) begin
      for (int d = 0; d < 2; d++) begin
        th = (d == 0) ? 0 : 300;
        for (int k = 0; k < NC; k++) begin
          xs = data[k*IW +: IW];
          x  = xs;
          v  = ord ? x + 2 * m_e1[d][k] - m_e2[d][k] : x + m_e1[d][k];
          y  = (v > th) ? 1 : ((v < -th) ? -1 : 0);
          e  = v - y * 512;
          if (e > EMAX)  begin e = EMAX;  m_ov[d][k] = 1; end
          if (e < -EMAX) begin e = -EMAX; m_ov[d][k] = 1; end
          m_e2[d][k] = m_e1[d][k];
          m_e1[d][k] = e;
          m_y[d][k]  = y;
        end
      end
      m_ovld = 1;
    end else begin
      m_ovld = 0;
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("out_valid[d%0d]", d),
          (d == 0) ? int'(ifa.out_valid) : int'(ifb.out_valid), m_ovld);
      for (int k = 0; k < NC; k++) begin
        chk($sformatf("sign[d%0d][ch%0d]", d, k),
            dec((d == 0) ? ifa.sign_out[2*k +: 2] : ifb.sign_out[2*k +: 2]), m_y[d][k]);
        chk($sformatf("ovf[d%0d][ch%0d]", d, k),
            (d == 0) ? int'(ifa.ovf[k]) : int'(ifb.ovf[k]), m_ov[d][k]);
      end
    end
  endtask

  task automatic drive(input bit clr, input bit ord, input bit vld,
                       input logic [DW-1:0] data);
    ifa.clear = clr; ifa.order_sel = ord; ifa.in_valid = vld; ifa.in_data = data;
    ifb.clear = clr; ifb.order_sel = ord; ifb.in_valid = vld; ifb.in_data = data;
  endtask

  // apply one cycle of stimulus, advance the model at the edge, check after it
  task automatic step(input bit clr, input bit ord, input bit vld,
                      input logic [DW-1:0] data);
    drive(clr, ord, vld, data);
    @(posedge clk);
    model_edge(clr, ord, vld, data);
    #1;
    check_all();
  endtask

  function automatic logic [DW-1:0] pack4(input int x0, input int x1,
                                          input int x2, input int x3);
    logic [DW-1:0] r;
    r = '0;
    r[0*IW +: IW] = IW'(x0);
    r[1*IW +: IW] = IW'(x1);
    r[2*IW +: IW] = IW'(x2);
    r[3*IW +: IW] = IW'(x3);
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_data(input bit big);
    logic [DW-1:0] r;
    for (int k = 0; k < NC; k++) begin
      if (big) r[k*IW +: IW] = IW'($urandom_range(0, (1 << IW) - 1));
      else     r[k*IW +: IW] = IW'(int'($urandom_range(0, 1200)) - 600);
    end
    return r;
  endfunction

  initial begin
    logic [DW-1:0] d256;
    int so2 [5];
    int n_acc;
    int exp0;
    bit vld;
    bit ord;
    so2 = '{1, -1, 1, 1, 1};
    checks = 0;
    failures = 0;
    rst = 1'b0;
    model_reset();
    drive(1'b0, 1'b0, 1'b0, '0);

    // reset with random activity on the inputs
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'($urandom), 1'($urandom), rand_data(1'b1));
      @(posedge clk); #1;
      check_all();
    end
    drive(1'b0, 1'b0, 1'b0, rand_data(1'b1));
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, rand_data(1'b1));

    // first order, +256 / -256 / 0
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1, pack4(256, -256, 0, 0));
      chk("fo_ch0", dec(ifa.sign_out[1:0]), (i % 2 == 0) ? 1 : 0);
      chk("fo_ch1", dec(ifa.sign_out[3:2]), (i % 2 == 0) ? -1 : 0);
      chk("fo_ch2", dec(ifa.sign_out[5:4]), 0);
    end
    step(1'b1, 1'b0, 1'b0, '0);

    // second order from zero history
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b1, pack4(256, 0, 0, 0));
      chk("so_ch0", dec(ifa.sign_out[1:0]), so2[i]);
    end
    step(1'b1, 1'b0, 1'b0, '0);

    // saturation on ch3
    for (int i = 1; i <= 13; i++) begin
      step(1'b0, 1'b0, 1'b1, pack4(0, 0, 0, 4095));
      chk("sat_ovf3", int'(ifa.ovf[3]), (i >= 10) ? 1 : 0);
      chk("sat_ovf0", int'(ifa.ovf[0]), 0);
    end
    step(1'b1, 1'b0, 1'b0, '0);
    chk("clr_ovf3", int'(ifa.ovf[3]), 0);
    chk("clr_sign3", dec(ifa.sign_out[7:6]), 0);

    // handshake gaps on a +256 first-order stream
    d256  = pack4(256, 256, 256, 256);
    n_acc = 0;
    exp0  = 0;
    for (int i = 0; i < 40; i++) begin
      vld = ($urandom_range(0, 2) != 0);
      step(1'b0, 1'b0, vld, d256);
      if (vld) begin
        n_acc++;
        exp0 = (n_acc % 2 == 1) ? 1 : 0;
      end
      chk("gap_ch0", dec(ifa.sign_out[1:0]), exp0);
    end

    // clear together with in_valid
    step(1'b1, 1'b0, 1'b1, d256);
    chk("clrv_ovld", int'(ifa.out_valid), 0);
    chk("clrv_sign", int'(ifa.sign_out), 0);
    chk("clrv_ovld_b", int'(ifb.out_valid), 0);

    // randomized traffic, with an asynchronous reset in the middle
    ord = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (i % 16 == 0) ord = 1'($urandom);
      if (i == 150) begin
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk); #1;
        check_all();
        rst = 1'b1;
      end
      step(($urandom_range(0, 19) == 0), ord, ($urandom_range(0, 3) != 0),
           rand_data(i >= 200));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
